// File: rtl/stream_sink_checker.sv
// Terminal consumer of a valid/ready stream: drives registered ready with optional LFSR
// backpressure, checks an incrementing data sequence and the sender's hold rules.
module stream_sink_checker #(
   parameter int unsigned WIDTH     = 9,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BEATS     = 300,
   parameter int unsigned BP_MODE   = 0,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             enable,
   input  logic             ready_in,
   input  logic             vaild,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             done,
   output logic [15:0]      beat_cnt,
   output logic [7:0]       err_cnt,
   output logic             proto_err,
   output logic [WIDTH-1:0] first_err_got,
   output logic [WIDTH-1:0] first_err_exp
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] prev_data;
   logic             prev_stall;
   logic [7:0]       lfsr;

   logic             accept_c;
   logic             last_c;
   logic             match_c;
   logic             bp_c;
   logic             lfsr_fb_c;
   logic [WIDTH-1:0] exp_inc_c;
   logic [WIDTH-1:0] exp_resync_c;

   // Handshake decode and next-state selection
   always_comb begin
      state_d      = state;
      accept_c     = (state == ST_RUN) && vaild && ready;
      last_c       = accept_c && (beat_cnt == 16'(BEATS - 1));
      match_c      = (data_in == exp_q);
      bp_c         = (BP_MODE != 0) ? (ready_in & lfsr[0]) : ready_in;
      lfsr_fb_c    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      exp_inc_c    = (exp_q == WIDTH'(DEPTH - 1)) ? '0 : exp_q + WIDTH'(1);
      exp_resync_c = WIDTH'((32'(data_in) + 32'd1) % DEPTH);
      case (state)
         ST_IDLE: if (enable) state_d = ST_RUN;
         ST_RUN:  if (last_c) state_d = ST_DONE;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s_rst) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Ready, LFSR, hold-rule monitor and sequence checker
   always_ff @(posedge clk) begin
      if (s_rst) begin
         ready         <= 1'b0;
         done          <= 1'b0;
         beat_cnt      <= '0;
         err_cnt       <= '0;
         proto_err     <= 1'b0;
         first_err_got <= '0;
         first_err_exp <= '0;
         exp_q         <= '0;
         prev_data     <= '0;
         prev_stall    <= 1'b0;
         lfsr          <= LFSR_SEED;
      end else begin
         ready <= (state == ST_RUN && !last_c) ? bp_c : 1'b0;
         done  <= (state_d == ST_DONE);
         if (state == ST_RUN) begin
            lfsr       <= {lfsr[6:0], lfsr_fb_c};
            prev_stall <= vaild & ~ready;
            prev_data  <= data_in;
            if (prev_stall && (!vaild || data_in != prev_data)) proto_err <= 1'b1;
         end else begin
            prev_stall <= 1'b0;
         end
         if (accept_c) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (match_c) begin
               exp_q <= exp_inc_c;
            end else begin
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               if (err_cnt == 8'd0) begin
                  first_err_got <= data_in;
                  first_err_exp <= exp_q;
               end
               exp_q <= exp_resync_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Bench for stream_sink_checker: two instances (plain and LFSR backpressure) driven by a
// random-valid source and compared each cycle against a rule-level reference model.
module tb_stream_sink_checker;

   localparam int DEPTH = 256;
   localparam int BEATS = 300;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic clk;
   logic [1:0]      rst, en, rin, vld, rdy, done, pe;
   logic [1:0][8:0] dat, fg, fe;
   logic [1:0][15:0] bc;
   logic [1:0][7:0]  ec;

   typedef struct {
      int       st;
      bit       rdy;
      int       expv;
      int       bc;
      int       ec;
      bit       pe;
      int       fg;
      int       fe;
      bit       stall;
      int       pdata;
      bit [7:0] lfsr;
   } model_t;

   model_t m[2];
   int     q0[$];
   int     q1[$];
   int     vprob[2];
   bit     auto_src[2];
   int     tests = 0;
   int     fails = 0;

   stream_sink_checker #(.BP_MODE(0)) dut0 (
      .clk(clk), .s_rst(rst[0]), .enable(en[0]), .ready_in(rin[0]), .vaild(vld[0]),
      .data_in(dat[0]), .ready(rdy[0]), .done(done[0]), .beat_cnt(bc[0]), .err_cnt(ec[0]),
      .proto_err(pe[0]), .first_err_got(fg[0]), .first_err_exp(fe[0]));

   stream_sink_checker #(.BP_MODE(1)) dut1 (
      .clk(clk), .s_rst(rst[1]), .enable(en[1]), .ready_in(rin[1]), .vaild(vld[1]),
      .data_in(dat[1]), .ready(rdy[1]), .done(done[1]), .beat_cnt(bc[1]), .err_cnt(ec[1]),
      .proto_err(pe[1]), .first_err_got(fg[1]), .first_err_exp(fe[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic int qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   // Source of k mod DEPTH for k < n, with an optional jump in the sequence and one bad value
   task automatic src_fill(input int i, input int n, input int err_at, input int err_val,
                           input int jump_at, input int jump);
      int v;
      if (i == 0) q0.delete(); else q1.delete();
      vld[i] = 1'b0;
      for (int k = 0; k < n; k++) begin
         v = (k + ((k >= jump_at) ? jump : 0)) % DEPTH;
         if (k == err_at) v = err_val;
         if (i == 0) q0.push_back(v); else q1.push_back(v);
      end
   endtask

   // Well-behaved sender: holds an offered beat until it is taken
   task automatic src_update(input int i, input bit acc);
      if (acc) begin
         if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (!(vld[i] && !acc)) begin
         if (qsize(i) > 0 && int'($urandom_range(99)) < vprob[i]) begin
            vld[i] = 1'b1;
            dat[i] = 9'(qfront(i));
         end else begin
            vld[i] = 1'b0;
            dat[i] = 9'($urandom);
         end
      end
   endtask

   task automatic model_update(input int i, input bit acc);
      bit last;
      bit bp;
      last = 1'b0;
      if (rst[i]) begin
         m[i] = '{default: 0};
         m[i].lfsr = 8'hA5;
      end else begin
         if (m[i].st == M_RUN) begin
            if (m[i].stall && (!vld[i] || int'(dat[i]) != m[i].pdata)) m[i].pe = 1'b1;
            m[i].stall = vld[i] && !m[i].rdy;
            m[i].pdata = int'(dat[i]);
         end else begin
            m[i].stall = 1'b0;
         end
         if (acc) begin
            m[i].bc++;
            last = (m[i].bc == BEATS);
            if (int'(dat[i]) == m[i].expv) begin
               m[i].expv = (m[i].expv + 1) % DEPTH;
            end else begin
               if (m[i].ec == 0) begin
                  m[i].fg = int'(dat[i]);
                  m[i].fe = m[i].expv;
               end
               if (m[i].ec < 255) m[i].ec++;
               m[i].expv = (int'(dat[i]) + 1) % DEPTH;
            end
         end
         bp = rin[i] && (i == 0 || m[i].lfsr[0]);
         m[i].rdy = (m[i].st == M_RUN && !last) ? bp : 1'b0;
         if (m[i].st == M_RUN) m[i].lfsr = {m[i].lfsr[6:0], ^(m[i].lfsr & 8'hB8)};
         if (m[i].st == M_IDLE && en[i]) m[i].st = M_RUN;
         else if (m[i].st == M_RUN && last) m[i].st = M_DONE;
      end
   endtask

   // One clock: predict accepts, advance model, compare both DUTs, then move the sources
   task automatic cycle();
      bit acc[2];
      for (int i = 0; i < 2; i++) acc[i] = (m[i].st == M_RUN) && vld[i] && m[i].rdy;
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_update(i, acc[i]);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d ready", i), int'(rdy[i]), int'(m[i].rdy));
         chk($sformatf("dut%0d done", i), int'(done[i]), int'(m[i].st == M_DONE));
         chk($sformatf("dut%0d beat_cnt", i), int'(bc[i]), m[i].bc);
         chk($sformatf("dut%0d err_cnt", i), int'(ec[i]), m[i].ec);
         chk($sformatf("dut%0d proto_err", i), int'(pe[i]), int'(m[i].pe));
         chk($sformatf("dut%0d first_err_got", i), int'(fg[i]), m[i].fg);
         chk($sformatf("dut%0d first_err_exp", i), int'(fe[i]), m[i].fe);
      end
      for (int i = 0; i < 2; i++) if (auto_src[i]) src_update(i, acc[i]);
   endtask

   task automatic run_until(input int i, input int target, input int budget);
      int n;
      n = 0;
      while (m[i].bc < target && n < budget) begin
         cycle();
         n++;
      end
      chk($sformatf("dut%0d beats reached within budget", i), int'(bc[i]), target);
   endtask

   task automatic start(input int i);
      en[i] = 1'b1;
      cycle();
      en[i] = 1'b0;
   endtask

   task automatic reset_one(input int i);
      rst[i] = 1'b1;
      cycle();
      rst[i] = 1'b0;
   endtask

   task automatic chk_reset_vals(input int i, input string tag);
      chk({tag, " ready"}, int'(rdy[i]), 0);
      chk({tag, " done"}, int'(done[i]), 0);
      chk({tag, " beat_cnt"}, int'(bc[i]), 0);
      chk({tag, " err_cnt"}, int'(ec[i]), 0);
      chk({tag, " proto_err"}, int'(pe[i]), 0);
      chk({tag, " first_err_got"}, int'(fg[i]), 0);
      chk({tag, " first_err_exp"}, int'(fe[i]), 0);
   endtask

   initial begin
      rst = 2'b11; en = '0; rin = 2'b11; vld = '0; dat = '0;
      auto_src[0] = 1'b1; auto_src[1] = 1'b1;
      vprob[0] = 100; vprob[1] = 50;
      cycle();
      cycle();
      chk_reset_vals(0, "reset dut0");
      chk_reset_vals(1, "reset dut1");

      // Back-to-back stream, no backpressure
      rst[0] = 1'b0;
      src_fill(0, BEATS, -1, 0, 1 << 20, 0);
      start(0);
      cycle();
      chk("t1 no accept in first RUN cycle", int'(bc[0]), 0);
      cycle();
      chk("t1 first accept in second RUN cycle", int'(bc[0]), 1);
      run_until(0, BEATS, 400);
      chk("t1 done", int'(done[0]), 1);
      chk("t1 beat_cnt", int'(bc[0]), 300);
      chk("t1 err_cnt", int'(ec[0]), 0);
      chk("t1 ready low after last", int'(rdy[0]), 0);
      repeat (3) cycle();
      chk("t1 no beats after done", int'(bc[0]), 300);

      // Legal wrap 255 -> 0
      reset_one(0);
      src_fill(0, 260, -1, 0, 1 << 20, 0);
      start(0);
      run_until(0, 260, 400);
      chk("t2 wrap err_cnt", int'(ec[0]), 0);

      // 256 in place of 0 at the wrap point
      reset_one(0);
      src_fill(0, BEATS, 256, 256, 1 << 20, 0);
      start(0);
      run_until(0, BEATS, 400);
      chk("t2 bad wrap err_cnt", int'(ec[0]), 1);
      chk("t2 first_err_got", int'(fg[0]), 256);
      chk("t2 first_err_exp", int'(fe[0]), 0);

      // Jump 2 -> 7 with random valid, then resync
      reset_one(0);
      vprob[0] = 60;
      src_fill(0, 12, -1, 0, 3, 4);
      start(0);
      run_until(0, 12, 200);
      chk("t3 err_cnt", int'(ec[0]), 1);
      chk("t3 first_err_exp", int'(fe[0]), 3);
      chk("t3 first_err_got", int'(fg[0]), 7);
      vprob[0] = 100;

      // Hold-rule violations driven by hand
      auto_src[0] = 1'b0;
      vld[0] = 1'b0;
      rin[0] = 1'b0;
      reset_one(0);
      start(0);
      vld[0] = 1'b1; dat[0] = 9'd5;
      cycle();
      cycle();
      chk("t4 holding is legal", int'(pe[0]), 0);
      chk("t4 no accept while ready low", int'(bc[0]), 0);
      dat[0] = 9'd6;
      cycle();
      chk("t4 data change flagged", int'(pe[0]), 1);
      vld[0] = 1'b0;
      repeat (3) cycle();
      chk("t4 proto_err sticky", int'(pe[0]), 1);
      reset_one(0);
      chk("t4 reset clears proto_err", int'(pe[0]), 0);
      start(0);
      vld[0] = 1'b1; dat[0] = 9'd5;
      cycle();
      vld[0] = 1'b0;
      cycle();
      chk("t4 valid drop flagged", int'(pe[0]), 1);
      rin[0] = 1'b1;
      auto_src[0] = 1'b1;

      // LFSR backpressure with random valid
      rst[1] = 1'b0;
      src_fill(1, BEATS, -1, 0, 1 << 20, 0);
      start(1);
      run_until(1, BEATS, 3000);
      chk("t5 done", int'(done[1]), 1);
      chk("t5 beat_cnt", int'(bc[1]), 300);
      chk("t5 err_cnt", int'(ec[1]), 0);
      chk("t5 proto_err", int'(pe[1]), 0);

      // Mid-run reset with an error already logged, then clean restart
      reset_one(0);
      src_fill(0, BEATS, 10, 99, 1 << 20, 0);
      start(0);
      run_until(0, 150, 300);
      chk("t6 errors seen before reset", int'(ec[0] != 0), 1);
      rst[0] = 1'b1;
      cycle();
      chk_reset_vals(0, "t6 mid-run reset");
      rst[0] = 1'b0;
      src_fill(0, BEATS, -1, 0, 1 << 20, 0);
      start(0);
      run_until(0, BEATS, 400);
      chk("t6 restart err_cnt", int'(ec[0]), 0);
      chk("t6 restart done", int'(done[0]), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
